// File: rtl/switch_conditioner.sv
// -----------------------------------------------------------------------------
// switch_conditioner
//
// Input stage for the counter driver. Turns raw, asynchronous, bouncing
// slide-switch / pushbutton pads into clean levels and single-cycle event
// pulses in the clk domain. sw_level feeds the driver's switches input; the
// rise, fall and long-press pulses go to the driver's control logic.
//
// Each channel has:
//   - a 2-flop synchronizer (sync_p0 -> sync_p1),
//   - a 4-state debounce FSM (LOW, CHK_HI, HIGH, CHK_LO) with one hold
//     counter. The counter debounces in the CHK_* states and times the long
//     press in HIGH.
//
// Ports:
//   clk        in   1       system clock
//   rst        in   1       asynchronous, active-high reset; clears every flop
//   sw_raw     in   NUM_SW  raw pad inputs, asynchronous to clk
//   sw_level   out  NUM_SW  debounced level
//   sw_rise    out  NUM_SW  1-cycle pulse when sw_level goes 0->1
//   sw_fall    out  NUM_SW  1-cycle pulse when sw_level goes 1->0
//   sw_long    out  NUM_SW  1-cycle pulse once sw_level has been high
//                           LONG_PRESS_CYCLES cycles
//   glitch_cnt out  8       saturating count of cycles with an aborted check
//                           (only when SWITCH_COND_GLITCH_CNT_EN is defined)
//
// Optional feature macro: SWITCH_COND_GLITCH_CNT_EN
// -----------------------------------------------------------------------------
module switch_conditioner #(
    parameter int          NUM_SW            = 2,
    parameter logic [15:0] DEBOUNCE_CYCLES   = 16'd50000,
    parameter logic [23:0] LONG_PRESS_CYCLES = 24'd5000000,
    parameter int          CNT_W             = 24
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_SW-1:0] sw_raw,
    output logic [NUM_SW-1:0] sw_level,
    output logic [NUM_SW-1:0] sw_rise,
    output logic [NUM_SW-1:0] sw_fall,
    output logic [NUM_SW-1:0] sw_long
`ifdef SWITCH_COND_GLITCH_CNT_EN
    ,
    output logic [7:0]        glitch_cnt
`endif
);

    typedef enum logic [1:0] {
        LOW    = 2'd0,
        CHK_HI = 2'd1,
        HIGH   = 2'd2,
        CHK_LO = 2'd3
    } state_t;

    // Last count value of a debounce window, the long-press trigger point and
    // the saturation value of the hold timer.
    localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES) - CNT_W'(1);
    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_PRESS_CYCLES) - CNT_W'(1);
    localparam logic [CNT_W-1:0] LONG_SAT  = CNT_W'(LONG_PRESS_CYCLES);

    logic [NUM_SW-1:0] sync_p0;
    logic [NUM_SW-1:0] sync_p1;

    state_t            state_p2 [NUM_SW];
    logic [CNT_W-1:0]  cnt_p2   [NUM_SW];

    state_t            state_d  [NUM_SW];
    logic [CNT_W-1:0]  cnt_d    [NUM_SW];
    logic [NUM_SW-1:0] rise_d;
    logic [NUM_SW-1:0] fall_d;
    logic [NUM_SW-1:0] long_d;

    // Stage p0/p1: two-flop synchronizer; sync_p1 is the clean sample s.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_p0 <= '0;
            sync_p1 <= '0;
        end else begin
            sync_p0 <= sw_raw;
            sync_p1 <= sync_p0;
        end
    end

    // Stage p2: per-channel debounce FSM, hold counter and registered pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_SW; i++) begin
                state_p2[i] <= LOW;
                cnt_p2[i]   <= '0;
            end
            sw_rise <= '0;
            sw_fall <= '0;
            sw_long <= '0;
        end else begin
            for (int i = 0; i < NUM_SW; i++) begin
                state_p2[i] <= state_d[i];
                cnt_p2[i]   <= cnt_d[i];
            end
            sw_rise <= rise_d;
            sw_fall <= fall_d;
            sw_long <= long_d;
        end
    end

    always_comb begin
        rise_d = '0;
        fall_d = '0;
        long_d = '0;
        for (int i = 0; i < NUM_SW; i++) begin
            state_d[i] = state_p2[i];
            cnt_d[i]   = cnt_p2[i];
            case (state_p2[i])
                LOW: begin
                    if (sync_p1[i]) begin
                        state_d[i] = CHK_HI;
                        cnt_d[i]   = CNT_W'(1);
                    end
                end
                CHK_HI: begin
                    if (!sync_p1[i]) begin
                        state_d[i] = LOW;
                        cnt_d[i]   = '0;
                    end else if (cnt_p2[i] == DEB_LAST) begin
                        state_d[i] = HIGH;
                        cnt_d[i]   = '0;
                        rise_d[i]  = 1'b1;
                    end else begin
                        cnt_d[i] = cnt_p2[i] + CNT_W'(1);
                    end
                end
                HIGH: begin
                    // Threshold uses the registered count, so the pulse still
                    // fires when s drops on the very same cycle.
                    if (cnt_p2[i] == LONG_LAST) begin
                        long_d[i] = 1'b1;
                    end
                    if (!sync_p1[i]) begin
                        state_d[i] = CHK_LO;
                        cnt_d[i]   = CNT_W'(1);
                    end else if (cnt_p2[i] != LONG_SAT) begin
                        // Saturating at LONG_SAT keeps the pulse from repeating.
                        cnt_d[i] = cnt_p2[i] + CNT_W'(1);
                    end
                end
                CHK_LO: begin
                    if (sync_p1[i]) begin
                        // Bounce while releasing: back to HIGH, long-press
                        // timer starts over.
                        state_d[i] = HIGH;
                        cnt_d[i]   = '0;
                    end else if (cnt_p2[i] == DEB_LAST) begin
                        state_d[i] = LOW;
                        cnt_d[i]   = '0;
                        fall_d[i]  = 1'b1;
                    end else begin
                        cnt_d[i] = cnt_p2[i] + CNT_W'(1);
                    end
                end
                default: begin
                    state_d[i] = LOW;
                    cnt_d[i]   = '0;
                end
            endcase
        end
    end

    // Level is high in HIGH and throughout the release check.
    always_comb begin
        sw_level = '0;
        for (int i = 0; i < NUM_SW; i++) begin
            sw_level[i] = (state_p2[i] == HIGH) || (state_p2[i] == CHK_LO);
        end
    end

`ifdef SWITCH_COND_GLITCH_CNT_EN
    logic abort_any;

    // One increment per cycle, however many channels abort together.
    always_comb begin
        abort_any = 1'b0;
        for (int i = 0; i < NUM_SW; i++) begin
            if (((state_p2[i] == CHK_HI) && (state_d[i] == LOW)) ||
                ((state_p2[i] == CHK_LO) && (state_d[i] == HIGH))) begin
                abort_any = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            glitch_cnt <= 8'd0;
        end else if (abort_any && (glitch_cnt != 8'hFF)) begin
            glitch_cnt <= glitch_cnt + 8'd1;
        end
    end
`endif

endmodule
